sprite_store_n: RTL
===================

Name: sprite_store_n

Overview:
- Parametrised per-line sprite store for the PPU; next generation of the fixed 10-slot DMG sprite store.
- During OAM scan it captures up to SLOTS in-range sprites: OAM index, line offset and X position.
- During render it compares the pixel X counter against every occupied slot. It returns the highest-priority (lowest slot number) match, registered.
- Fetched slots are retired so that overlapping sprites at the same X are served in turn.

Parameters:
- SLOTS, 10: number of sprite slots (1..32).
- IDX_W, 6: OAM index width (index = oam_a[7:2] on DMG).
- LINE_W, 4: sprite line-offset width.
- X_W, 8: sprite and pixel X width.

Ports:
- clk  in  1  PPU clock; all state changes on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- scan_start  in  1  pulse; begins a new line and empties the store.
- store_req  in  1  the current scanned sprite is in range; store it this cycle.
- store_idx  in  IDX_W  OAM index of the scanned sprite.
- store_line  in  LINE_W  line within the sprite.
- store_x  in  X_W  sprite X.
- match_en  in  1  render active; enables comparison.
- pix_x  in  X_W  current pixel X.
- fetch_done  in  1  pulse; the sprite in the hit_* registers has been fetched.
- count  out  $clog2(SLOTS+1)  number of occupied slots.
- full  out  1  count == SLOTS.
- overflow  out  1  sticky; a store_req was dropped this line.
- hit  out  1  a match is held in hit_*.
- hit_slot  out  $clog2(SLOTS)  slot number of the held match.
- hit_idx  out  IDX_W  index of the held match.
- hit_line  out  LINE_W  line of the held match.

Behaviour:
- Clock and reset: single clock domain, clk. Reset is synchronous, active-low: rst_n sampled low at a rising edge resets the block.
- Reset values: count=0, full=0, overflow=0, hit=0, hit_slot=0, hit_idx=0, hit_line=0, all valid bits 0. Slot contents are don't-care.
- Reset mid-operation: rst_n low aborts any scan or render in progress. The store is empty from the next cycle.
- Storage: per slot, a valid bit plus idx/line/x registers. Slot contents are not cleared on scan_start; only the valid bits are.
- scan_start: clears all valid bits, count, overflow, hit and the hit_* outputs.
  - If store_req is asserted in the same cycle, the store lands in slot 0 and count becomes 1.
- Store:
  - If store_req and not full: write slot[count], set its valid bit, count += 1.
  - If store_req and full: discard the sprite, set overflow. Slot contents are unchanged.
- Match (comparison is combinational, result registered; latency 1 cycle):
  - Candidate slots are those with valid && x == pix_x.
  - Priority encoder: the lowest candidate slot wins.
  - When match_en=1 and hit=0 and a candidate exists, next cycle: hit=1, hit_slot/idx/line loaded from the winner.
  - While hit=1, the hit_* registers hold regardless of pix_x; no new capture occurs.
  - match_en=0: no new capture. An existing hit is held.
- Retire: fetch_done while hit=1 clears valid[hit_slot] and sets hit=0 in the same edge.
  - The next comparison uses the updated valid bits, so a second sprite at the same X hits on the following cycle.
  - count is not decremented by a retire; it reflects slots filled this line.
  - fetch_done while hit=0 is ignored.
- Simultaneous store_req and fetch_done: both take effect independently. A store never targets a retired slot because count is monotonic within a line.
- A slot stored this cycle is eligible for matching from the next cycle.

Optional Feature:
- Macro: SPRITE_STORE_READBACK_EN.
- Defined: adds debug ports rd_slot (in, $clog2(SLOTS)) and rd_data (out, 1+X_W+IDX_W+LINE_W). rd_data = {valid, x, idx, line} of rd_slot, combinational. rd_slot >= SLOTS returns all zeros.
- Undefined: these ports and their read mux are absent. All other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with store_req=1 -> count=0, full=0, overflow=0, hit=0 after release.
- Fill and overflow (SLOTS=10): scan_start, then 12 store_req with idx 0..11 -> count=10, full=1, overflow=1; idx 10 and 11 are never returned by any match.
- Priority and latency: store (idx5,x=20), (idx9,x=20), (idx3,x=40); match_en=1, pix_x=20 -> one cycle later hit=1, hit_slot=0, hit_idx=5.
  - Pulse fetch_done -> next capture gives hit_slot=1, hit_idx=9.
  - Second fetch_done -> no hit at x=20.
- Hold behaviour: with hit=1 (idx5), sweep pix_x 21..30 -> hit_idx stays 5; fetch_done with hit=0 changes nothing.
- Simultaneous events: scan_start plus store_req(idx7,x=8) in one cycle while the previous line had count=4 -> count=1; slot 0 holds idx7; pix_x=8 gives hit_idx=7.
- Readback (macro defined): after the priority test, rd_slot=1 -> rd_data={0,20,9,line}; rd_slot=2 -> valid=1, x=40, idx=3.

Source files
------------

// File: rtl/sprite_store_n.sv
// sprite_store_n -- per-line sprite store for the PPU.
//
// During OAM scan, in-range sprites are captured into up to SLOTS slots.
// Each slot holds the OAM index, the line offset and the X position. During
// render, the pixel X counter is compared against every occupied slot. The
// lowest-numbered matching slot is captured into the hit_* registers one
// cycle later. Fetched slots are retired, so sprites that overlap at the
// same X are served in turn.
//
// Optional build macro: SPRITE_STORE_READBACK_EN adds the debug ports
// rd_slot/rd_data. The default build (macro undefined) has no readback.
//
// Ports:
//   clk         PPU clock, rising edge
//   rst_n       synchronous active-low reset
//   scan_start  pulse: begin a new line, empty the store
//   store_req   store the current scanned sprite this cycle
//   store_idx   OAM index of the scanned sprite
//   store_line  line within the sprite
//   store_x     sprite X
//   match_en    render active, enables comparison
//   pix_x       current pixel X
//   fetch_done  pulse: the sprite held in hit_* has been fetched
//   count       slots filled this line (not decremented by retire)
//   full        count == SLOTS
//   overflow    sticky: a store_req was dropped this line
//   hit         a match is held in hit_*
//   hit_slot    slot number of the held match
//   hit_idx     OAM index of the held match
//   hit_line    line offset of the held match
//   rd_slot     (readback only) slot to inspect
//   rd_data     (readback only) {valid, x, idx, line} of rd_slot, 0 if out of range
//
// Handshake semantics: store_req and fetch_done are single-cycle strobes
// with no back-pressure. A store_req is always consumed on the edge where it
// is sampled: it is either written or dropped and flagged in overflow.
// fetch_done is consumed only while hit=1 and is ignored otherwise.
// hit acts as the valid of the hit_* bundle, and fetch_done acts as its
// ready. hit_* hold until that pair completes.

module sprite_store_n #(
   parameter int SLOTS  = 10,
   parameter int IDX_W  = 6,
   parameter int LINE_W = 4,
   parameter int X_W    = 8,
   localparam int CNT_W  = $clog2(SLOTS + 1),
   localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              scan_start,
   input  logic              store_req,
   input  logic [IDX_W-1:0]  store_idx,
   input  logic [LINE_W-1:0] store_line,
   input  logic [X_W-1:0]    store_x,
   input  logic              match_en,
   input  logic [X_W-1:0]    pix_x,
   input  logic              fetch_done,
`ifdef SPRITE_STORE_READBACK_EN
   input  logic [SLOT_W-1:0] rd_slot,
   output logic [X_W+IDX_W+LINE_W:0] rd_data,
`endif
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              overflow,
   output logic              hit,
   output logic [SLOT_W-1:0] hit_slot,
   output logic [IDX_W-1:0]  hit_idx,
   output logic [LINE_W-1:0] hit_line
);

   localparam logic [CNT_W-1:0] SLOTS_CNT = CNT_W'(SLOTS);

   logic [SLOTS-1:0]  valid;
   logic [SLOTS-1:0]  valid_nxt;
   logic [IDX_W-1:0]  slot_idx  [SLOTS];
   logic [LINE_W-1:0] slot_line [SLOTS];
   logic [X_W-1:0]    slot_x    [SLOTS];

   logic              store_ok;
   logic              retire;
   logic              wr_en;
   logic [SLOT_W-1:0] wr_slot;
   logic [SLOT_W-1:0] wr_at;
   logic              cand_found;
   logic [SLOT_W-1:0] cand_slot;

   assign full     = (count == SLOTS_CNT);
   assign store_ok = store_req && !full;
   assign retire   = fetch_done && hit;
   // count is monotonic within a line, so the next free slot is count itself.
   assign wr_slot  = SLOT_W'(count);
   // A scan_start empties the store, so a store in that cycle lands in slot 0.
   assign wr_at    = scan_start ? '0 : wr_slot;
   assign wr_en    = rst_n && store_req && (scan_start || !full);

   // Priority encoder: walk from the top so the lowest candidate wins.
   always_comb begin
      cand_found = 1'b0;
      cand_slot  = '0;
      for (int i = SLOTS - 1; i >= 0; i--) begin
         if (valid[i] && (slot_x[i] == pix_x)) begin
            cand_found = 1'b1;
            cand_slot  = SLOT_W'(i);
         end
      end
   end

   // The store target (slot count) is always above any hit_slot (< count),
   // so setting one bit and clearing another never collide.
   always_comb begin
      valid_nxt = valid;
      if (store_ok) valid_nxt[wr_slot]  = 1'b1;
      if (retire)   valid_nxt[hit_slot] = 1'b0;
   end

   // Slot payload has no reset; only the valid bits qualify it.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         slot_idx[wr_at]  <= store_idx;
         slot_line[wr_at] <= store_line;
         slot_x[wr_at]    <= store_x;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid    <= '0;
         count    <= '0;
         overflow <= 1'b0;
         hit      <= 1'b0;
         hit_slot <= '0;
         hit_idx  <= '0;
         hit_line <= '0;
      end else if (scan_start) begin
         valid    <= '0;
         count    <= '0;
         overflow <= 1'b0;
         hit      <= 1'b0;
         hit_slot <= '0;
         hit_idx  <= '0;
         hit_line <= '0;
         if (store_req) begin
            valid[0] <= 1'b1;
            count    <= CNT_W'(1);
         end
      end else begin
         valid <= valid_nxt;
         if (store_ok)
            count <= count + CNT_W'(1);
         if (store_req && full)
            overflow <= 1'b1;
         // Retire and capture are exclusive: retire needs hit=1, capture needs
         // hit=0. The next capture therefore sees the updated valid bits.
         if (retire)
            hit <= 1'b0;
         if (match_en && !hit && cand_found) begin
            hit      <= 1'b1;
            hit_slot <= cand_slot;
            hit_idx  <= slot_idx[cand_slot];
            hit_line <= slot_line[cand_slot];
         end
      end
   end

`ifdef SPRITE_STORE_READBACK_EN
   localparam logic [SLOT_W:0] SLOTS_RD = (SLOT_W + 1)'(SLOTS);

   always_comb begin
      rd_data = '0;
      if ({1'b0, rd_slot} < SLOTS_RD)
         rd_data = {valid[rd_slot], slot_x[rd_slot], slot_idx[rd_slot], slot_line[rd_slot]};
   end
`endif

endmodule
